// File: rtl/door_lock_controller_if.sv
// Signal bundle between the door sensors/keypad and the lock controller.
// The master side drives sensors and keypad inputs; the slave side is the
// controller, which drives the lock actuator and status outputs.
interface door_lock_controller_if #(
  parameter int NUM_SENSORS = 4,
  parameter int CODE_WIDTH  = 16,
  parameter int MAX_FAILS   = 3
);
  logic [NUM_SENSORS-1:0]           door_motion_sensor;
  logic                             unlock_req;
  logic [CODE_WIDTH-1:0]            unlock_code;
  logic [CODE_WIDTH-1:0]            stored_code;
  logic                             manual_lock;
  logic                             lock_door;
  logic                             alarm;
  logic                             lockout_active;
  logic [$clog2(MAX_FAILS+1)-1:0]   fail_count;

  modport master (
    output door_motion_sensor, unlock_req, unlock_code, stored_code, manual_lock,
    input  lock_door, alarm, lockout_active, fail_count
  );

  modport slave (
    input  door_motion_sensor, unlock_req, unlock_code, stored_code, manual_lock,
    output lock_door, alarm, lockout_active, fail_count
  );
endinterface

// File: rtl/door_lock_controller.sv
// Door lock controller: debounced motion sensors, code unlock, motion-extended
// auto-relock, manual lock and a failed-attempt lockout with alarm.
// All outputs are registered; nothing flows combinationally from input to output.
module door_lock_controller #(
  parameter int NUM_SENSORS     = 4,
  parameter int CODE_WIDTH      = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AUTOLOCK_CYCLES = 1000,
  parameter int MAX_FAILS       = 3,
  parameter int LOCKOUT_CYCLES  = 5000
) (
  input logic                   clk,
  input logic                   rst,
  door_lock_controller_if.slave bus
);

  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int AW = $clog2(AUTOLOCK_CYCLES) + 1;
  localparam int LW = $clog2(LOCKOUT_CYCLES) + 1;

  localparam logic [DW-1:0] DB_LAST      = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0] AUTO_LOAD    = AW'(AUTOLOCK_CYCLES);
  localparam logic [LW-1:0] LOCKOUT_LOAD = LW'(LOCKOUT_CYCLES);
  localparam logic [FW-1:0] FAIL_LIMIT   = FW'(MAX_FAILS);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } state_t;

  logic [NUM_SENSORS-1:0] r_filt;
  logic [DW-1:0]          r_db_cnt [NUM_SENSORS];
  logic                   w_motion;

  state_t                 r_state, w_state_nxt;
  logic [AW-1:0]          r_timer, w_timer_nxt;
  logic [LW-1:0]          r_lock_cnt, w_lock_cnt_nxt;
  logic [FW-1:0]          r_fail, w_fail_nxt, w_fail_inc;
  logic                   r_lock_door, r_alarm, r_lockout;
  logic                   w_lock_nxt, w_alarm_nxt;
  logic                   w_code_ok;

  // Per-sensor debounce: adopt the raw value after DEBOUNCE_CYCLES consecutive mismatching edges.
  // NOTE: the counter array is tiny, so it is reset with everything else; a
  // large storage array would normally be left out of the reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt <= '0;
      for (int i = 0; i < NUM_SENSORS; i++) r_db_cnt[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      for (int i = 0; i < NUM_SENSORS; i++) begin
        if (bus.door_motion_sensor[i] != r_filt[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_filt[i]   <= bus.door_motion_sensor[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_motion   = |r_filt;
  assign w_code_ok  = (bus.unlock_code == bus.stored_code);
  assign w_fail_inc = r_fail + FW'(1);

  // Next-state, counter and output decode; outputs follow the next state so they register cleanly.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_lock_cnt_nxt = r_lock_cnt;
    w_fail_nxt     = r_fail;
    unique case (r_state)
      ST_LOCKED: begin
        // manual_lock has priority: a simultaneous request is dropped entirely.
        if (!bus.manual_lock && bus.unlock_req) begin
          if (w_code_ok) begin
            w_state_nxt = ST_UNLOCKED;
            w_timer_nxt = AUTO_LOAD;
            w_fail_nxt  = '0;
          end else if (r_fail != FAIL_LIMIT) begin
            w_fail_nxt = w_fail_inc;
            if (w_fail_inc == FAIL_LIMIT) begin
              w_state_nxt    = ST_LOCKOUT;
              w_lock_cnt_nxt = LOCKOUT_LOAD;
            end
          end
        end
      end
      ST_UNLOCKED: begin
        // Relock on the edge where the timer would decrement to zero.
        if (bus.manual_lock) begin
          w_state_nxt = ST_LOCKED;
        end else if (w_motion) begin
          w_timer_nxt = AUTO_LOAD;
        end else if (r_timer <= AW'(1)) begin
          w_state_nxt = ST_LOCKED;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer - AW'(1);
        end
      end
      ST_LOCKOUT: begin
        if (r_lock_cnt <= LW'(1)) begin
          w_state_nxt    = ST_LOCKED;
          w_lock_cnt_nxt = '0;
          w_fail_nxt     = '0;
        end else begin
          w_lock_cnt_nxt = r_lock_cnt - LW'(1);
        end
      end
      default: w_state_nxt = ST_LOCKED;
    endcase
    w_lock_nxt  = (w_state_nxt != ST_UNLOCKED);
    w_alarm_nxt = (w_state_nxt == ST_LOCKOUT);
  end

  // State, counters and registered outputs; reset aborts any state, including lockout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_LOCKED;
      r_timer     <= '0;
      r_lock_cnt  <= '0;
      r_fail      <= '0;
      r_lock_door <= 1'b1;
      r_alarm     <= 1'b0;
      r_lockout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_lock_cnt  <= w_lock_cnt_nxt;
      r_fail      <= w_fail_nxt;
      r_lock_door <= w_lock_nxt;
      r_alarm     <= w_alarm_nxt;
      r_lockout   <= w_alarm_nxt;
    end
  end

  assign bus.lock_door      = r_lock_door;
  assign bus.alarm          = r_alarm;
  assign bus.lockout_active = r_lockout;
  assign bus.fail_count     = r_fail;

endmodule
